// File: rtl/mem_stage_lsu.sv
// Memory stage of the 5-stage RISC-V pipeline.
// Issues load/store accesses over a req/ready handshake, aligns store data,
// extends load data, stalls the pipe while memory is busy, and holds the
// M->W pipeline register.
//
// Handshake: dmem_req is held high until a cycle with dmem_ready=1. That
// cycle completes the access, and dmem_rdata is valid in that cycle only.
// The request attributes (addr/we/be/wdata) stay stable while dmem_req=1,
// because upstream holds the _M inputs whenever stall_M=1.
module mem_stage_lsu #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        write_enable_RF_M,
  input  logic        write_enable_dmem_M,
  input  logic        read_enable_dmem_M,
  input  logic [2:0]  funct3_M,
  input  logic [1:0]  write_back_M,
  input  logic [31:0] alu_rsl_M,
  input  logic [31:0] wd_M,
  input  logic [31:0] imm_extended_M,
  input  logic [4:0]  rd_M,
  input  logic [31:0] pc4_M,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic        stall_M,
  output logic        write_enable_RF_W,
  output logic [1:0]  write_back_W,
  output logic [31:0] alu_rsl_W,
  output logic [31:0] imm_extended_W,
  output logic [4:0]  rd_W,
  output logic [31:0] pc4_W,
  output logic [31:0] read_data_W,
  output logic        misalign_W,
  output logic        bus_err_W,
  output logic        fsm_state
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;

  logic        is_store, is_load, acc, misalign, acc_ok;
  logic [1:0]  size;
  logic        req_raw, stall_raw, complete, timeout;
  logic [31:0] rdata_sh, ld_ext, st_wdata;
  logic [3:0]  st_be;

  // A store wins when both enables are set.
  assign is_store = write_enable_dmem_M;
  assign is_load  = read_enable_dmem_M & ~write_enable_dmem_M;
  assign acc      = write_enable_dmem_M | read_enable_dmem_M;
  assign size     = funct3_M[1:0];

  // Access-size and alignment decode; size 2'b11 is treated as a word.
  always_comb begin
    misalign = 1'b0;
    if (acc) begin
      if (size == 2'b01)
        misalign = alu_rsl_M[0];
      else if (size[1])
        misalign = (alu_rsl_M[1:0] != 2'b00);
    end
  end

  assign acc_ok = acc & ~misalign;

  // State and wait-counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Next state, request, stall, completion and timeout decode.
  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    req_raw   = 1'b0;
    stall_raw = 1'b0;
    complete  = 1'b0;
    timeout   = 1'b0;
    case (state)
      S_IDLE: begin
        if (acc_ok) begin
          req_raw = 1'b1;
          if (dmem_ready) begin
            complete = 1'b1;
          end else begin
            stall_raw = 1'b1;
            state_nx  = S_WAIT;
            cnt_nx    = '0;
          end
        end
      end
      S_WAIT: begin
        req_raw = 1'b1;
        if (dmem_ready) begin
          complete = 1'b1;
          state_nx = S_IDLE;
          cnt_nx   = '0;
        end else if (cnt == CNT_LAST) begin
          // Give up: release the pipe so the faulting instruction retires
          // into W as a bus error.
          timeout  = 1'b1;
          state_nx = S_IDLE;
          cnt_nx   = '0;
        end else begin
          stall_raw = 1'b1;
          cnt_nx    = cnt + 1'b1;
        end
      end
      default: begin
        state_nx = S_IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  // Reset must silence the bus and the stall at once, even with a live _M access.
  assign dmem_req   = req_raw & rst_n;
  assign stall_M    = stall_raw & rst_n;
  assign dmem_we    = dmem_req & write_enable_dmem_M;
  assign dmem_addr  = {alu_rsl_M[31:2], 2'b00};
  assign dmem_be    = (dmem_req & is_store) ? st_be : 4'b0000;
  assign dmem_wdata = st_wdata;
  assign fsm_state  = (state == S_WAIT);

  // Store lane enables and lane-replicated store data.
  always_comb begin
    st_be    = 4'b1111;
    st_wdata = wd_M;
    case (size)
      2'b00: begin
        st_be    = 4'b0001 << alu_rsl_M[1:0];
        st_wdata = {4{wd_M[7:0]}};
      end
      2'b01: begin
        st_be    = alu_rsl_M[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{wd_M[15:0]}};
      end
      default: begin
        st_be    = 4'b1111;
        st_wdata = wd_M;
      end
    endcase
  end

  assign rdata_sh = dmem_rdata >> {alu_rsl_M[1:0], 3'b000};

  // Load lane select and sign/zero extension (funct3[2] = unsigned).
  always_comb begin
    ld_ext = rdata_sh;
    case (size)
      2'b00:   ld_ext = funct3_M[2] ? {24'b0, rdata_sh[7:0]}
                                    : {{24{rdata_sh[7]}}, rdata_sh[7:0]};
      2'b01:   ld_ext = funct3_M[2] ? {16'b0, rdata_sh[15:0]}
                                    : {{16{rdata_sh[15]}}, rdata_sh[15:0]};
      default: ld_ext = rdata_sh;
    endcase
  end

  // M->W register: a bubble while stalled, otherwise the instruction retires.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      write_enable_RF_W <= 1'b0;
      write_back_W      <= '0;
      alu_rsl_W         <= '0;
      imm_extended_W    <= '0;
      rd_W              <= '0;
      pc4_W             <= '0;
      read_data_W       <= '0;
      misalign_W        <= 1'b0;
      bus_err_W         <= 1'b0;
    end else if (stall_M) begin
      write_enable_RF_W <= 1'b0;
      write_back_W      <= '0;
      alu_rsl_W         <= '0;
      imm_extended_W    <= '0;
      rd_W              <= '0;
      pc4_W             <= '0;
      read_data_W       <= '0;
      misalign_W        <= 1'b0;
      bus_err_W         <= 1'b0;
    end else begin
      write_enable_RF_W <= write_enable_RF_M & ~misalign & ~timeout;
      write_back_W      <= write_back_M;
      alu_rsl_W         <= alu_rsl_M;
      imm_extended_W    <= imm_extended_M;
      rd_W              <= rd_M;
      pc4_W             <= pc4_M;
      read_data_W       <= (complete & is_load) ? ld_ext : 32'b0;
      misalign_W        <= misalign;
      bus_err_W         <= timeout;
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Testbench for mem_stage_lsu: randomized instruction stream with a
// latency-programmable memory responder, a byte-level reference memory,
// and a scoreboard of expected M->W register contents.
module tb_mem_stage_lsu;

  localparam int TIMEOUT = 16;
  localparam int W       = 138;

  logic        clk, rst_n;
  logic        write_enable_RF_M, write_enable_dmem_M, read_enable_dmem_M;
  logic [2:0]  funct3_M;
  logic [1:0]  write_back_M;
  logic [31:0] alu_rsl_M, wd_M, imm_extended_M, pc4_M;
  logic [4:0]  rd_M;
  logic        dmem_req, dmem_we, dmem_ready;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        stall_M, write_enable_RF_W, misalign_W, bus_err_W, fsm_state;
  logic [1:0]  write_back_W;
  logic [31:0] alu_rsl_W, imm_extended_W, pc4_W, read_data_W;
  logic [4:0]  rd_W;

  mem_stage_lsu #(.TIMEOUT_CYCLES(TIMEOUT), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .write_enable_RF_M(write_enable_RF_M), .write_enable_dmem_M(write_enable_dmem_M),
    .read_enable_dmem_M(read_enable_dmem_M), .funct3_M(funct3_M),
    .write_back_M(write_back_M), .alu_rsl_M(alu_rsl_M), .wd_M(wd_M),
    .imm_extended_M(imm_extended_M), .rd_M(rd_M), .pc4_M(pc4_M),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready),
    .dmem_rdata(dmem_rdata), .stall_M(stall_M),
    .write_enable_RF_W(write_enable_RF_W), .write_back_W(write_back_W),
    .alu_rsl_W(alu_rsl_W), .imm_extended_W(imm_extended_W), .rd_W(rd_W),
    .pc4_W(pc4_W), .read_data_W(read_data_W), .misalign_W(misalign_W),
    .bus_err_W(bus_err_W), .fsm_state(fsm_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- shared state ----------------
  int          assert_cnt = 0;
  int          fail_cnt   = 0;
  logic [W-1:0] exp_q[$];
  logic        mon_en = 1'b0;
  int          instr_id = 0;
  int          cur_lat = 0;
  logic        exp_req = 1'b0;
  logic        exp_we = 1'b0;
  logic [31:0] exp_addr = '0;
  logic [3:0]  exp_be = '0;
  logic [31:0] exp_wdata = '0;
  logic [7:0]  ref_bytes[256];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    assert_cnt++;
    if (act !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_w(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    assert_cnt++;
    if (act !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- memory responder ----------------
  // Answers each request after cur_lat unanswered cycles; checks bus fields.
  initial begin
    logic [31:0] phys[64];
    int wc;
    int last_id;
    logic [31:0] word;
    for (int i = 0; i < 64; i++) phys[i] = '0;
    wc = 0;
    last_id = -1;
    dmem_ready = 1'b0;
    dmem_rdata = '0;
    forever begin
      @(negedge clk);
      if (instr_id != last_id) begin
        wc = 0;
        last_id = instr_id;
      end
      dmem_ready = 1'b0;
      dmem_rdata = $urandom;
      if (dmem_req) begin
        if (!exp_req) begin
          chk("spurious_req", {31'b0, dmem_req}, 32'd0);
        end else begin
          chk("dmem_addr", dmem_addr, exp_addr);
          chk("dmem_we", {31'b0, dmem_we}, {31'b0, exp_we});
          chk("dmem_be", {28'b0, dmem_be}, {28'b0, exp_be});
          if (exp_we) chk("dmem_wdata", dmem_wdata, exp_wdata);
        end
        if (wc == cur_lat) begin
          word = phys[dmem_addr[7:2]];
          dmem_ready = 1'b1;
          dmem_rdata = word;
          if (dmem_we) begin
            for (int b = 0; b < 4; b++)
              if (dmem_be[b]) word[8*b +: 8] = dmem_wdata[8*b +: 8];
            phys[dmem_addr[7:2]] = word;
          end
        end else begin
          wc++;
        end
      end
    end
  end

  // ---------------- monitor ----------------
  // Each edge taken with stall_M low retires one instruction into W.
  initial begin
    logic prev_live, prev_stall;
    logic [W-1:0] got, want;
    prev_live = 1'b0;
    prev_stall = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (prev_live) begin
        if (prev_stall) begin
          chk("w_bubble", {29'b0, write_enable_RF_W, misalign_W, bus_err_W}, 32'd0);
        end else if (exp_q.size() == 0) begin
          chk("sb_empty", exp_q.size(), 32'd1);
        end else begin
          got = {write_enable_RF_W, write_back_W, alu_rsl_W, imm_extended_W, rd_W,
                 pc4_W, read_data_W, misalign_W, bus_err_W};
          want = exp_q.pop_front();
          chk_w("w_reg", got, want);
        end
      end
      prev_live = mon_en;
      prev_stall = stall_M;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic we_rf, input logic we_d, input logic re_d,
                       input logic [2:0] f3, input logic [1:0] wb, input logic [31:0] alu,
                       input logic [31:0] wd, input logic [31:0] imm, input logic [4:0] rd,
                       input logic [31:0] pc4);
    write_enable_RF_M   = we_rf;
    write_enable_dmem_M = we_d;
    read_enable_dmem_M  = re_d;
    funct3_M            = f3;
    write_back_M        = wb;
    alu_rsl_M           = alu;
    wd_M                = wd;
    imm_extended_M      = imm;
    rd_M                = rd;
    pc4_M               = pc4;
  endtask

  task automatic drive_nop();
    exp_req = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 3'b000, 2'b00, 32'd0, 32'd0, 32'd0, 5'd0, 32'd0);
    instr_id++;
  endtask

  // Issue one instruction (called at posedge+1), predict its result, wait for acceptance.
  task automatic issue(input logic we_rf, input logic we_d, input logic re_d,
                       input logic [2:0] f3, input logic [31:0] alu, input logic [31:0] wd,
                       input int lat);
    logic [1:0]  wb;
    logic [31:0] imm, pc4, val;
    logic [4:0]  rd;
    logic        acc, is_ld, is_st, mis, berr, done;
    int          nbytes, base, exp_stall, stalls, cyc;
    wb  = 2'($urandom_range(0, 3));
    imm = $urandom;
    pc4 = $urandom;
    rd  = 5'($urandom_range(0, 31));
    acc   = we_d | re_d;
    is_st = we_d;
    is_ld = re_d & ~we_d;
    nbytes = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    mis  = acc && ((int'(alu[1:0]) % nbytes) != 0);
    berr = acc && !mis && (lat > TIMEOUT);
    done = acc && !mis && !berr;
    base = int'(alu[7:0]);
    exp_req   = acc && !mis;
    exp_we    = we_d;
    exp_addr  = alu & 32'hFFFF_FFFC;
    exp_be    = 4'b0000;
    exp_wdata = '0;
    if (is_st) begin
      for (int i = 0; i < nbytes; i++) exp_be[int'(alu[1:0]) + i] = 1'b1;
      if (nbytes == 1)      exp_wdata = 32'(wd[7:0]) * 32'h0101_0101;
      else if (nbytes == 2) exp_wdata = 32'(wd[15:0]) * 32'h0001_0001;
      else                  exp_wdata = wd;
    end
    val = '0;
    if (done && is_ld) begin
      for (int i = 0; i < nbytes; i++)
        val = val | (32'(ref_bytes[base + i]) << (8 * i));
      if (!f3[2] && nbytes < 4 && val[8*nbytes-1])
        val = val - (32'd1 << (8 * nbytes));
    end
    if (done && is_st)
      for (int i = 0; i < nbytes; i++) ref_bytes[base + i] = 8'(wd >> (8 * i));
    exp_q.push_back({we_rf & ~mis & ~berr, wb, alu, imm, rd, pc4, val, mis, berr});
    exp_stall = (acc && !mis) ? ((lat > TIMEOUT) ? TIMEOUT : lat) : 0;
    cur_lat = lat;
    drive(we_rf, we_d, re_d, f3, wb, alu, wd, imm, rd, pc4);
    instr_id++;
    stalls = 0;
    cyc = 0;
    forever begin
      @(negedge clk);
      #2;
      if (!stall_M) break;
      stalls++;
      cyc++;
      if (cyc > 40) begin
        chk("accept_timeout", {31'b0, stall_M}, 32'd0);
        break;
      end
    end
    @(posedge clk);
    #1;
    chk("stall_cycles", stalls, exp_stall);
  endtask

  task automatic ld(input logic [2:0] f3, input logic [31:0] alu, input int lat);
    issue(1'b1, 1'b0, 1'b1, f3, alu, $urandom, lat);
  endtask

  task automatic st(input logic [2:0] f3, input logic [31:0] alu, input logic [31:0] wd,
                    input int lat);
    issue(1'b0, 1'b1, 1'b0, f3, alu, wd, lat);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [2:0] ld_f3[5];
    int kind, r, lat;
    logic [2:0] f3;
    logic [31:0] alu;
    ld_f3[0] = 3'b000; ld_f3[1] = 3'b001; ld_f3[2] = 3'b010;
    ld_f3[3] = 3'b100; ld_f3[4] = 3'b101;
    for (int i = 0; i < 256; i++) ref_bytes[i] = 8'h00;

    // Reset with a live aligned load on the _M inputs.
    rst_n = 1'b0;
    drive(1'b1, 1'b0, 1'b1, 3'b010, 2'b01, 32'h100, 32'd0, 32'd5, 5'd3, 32'd8);
    exp_req = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req", {31'b0, dmem_req}, 32'd0);
    chk("rst_stall", {31'b0, stall_M}, 32'd0);
    chk("rst_state", {31'b0, fsm_state}, 32'd0);
    chk("rst_w", {write_enable_RF_W, misalign_W, bus_err_W, rd_W, write_back_W}, 32'd0);
    chk("rst_rdata", read_data_W, 32'd0);
    chk("rst_alu", alu_rsl_W, 32'd0);
    drive_nop();
    rst_n = 1'b1;
    mon_en = 1'b1;

    // Directed accesses.
    st(3'b010, 32'h100, 32'hDEAD_BEEF, 1);
    ld(3'b010, 32'h100, 0);                 // lw, same-cycle ready
    st(3'b010, 32'h100, 32'h8011_2233, 0);
    ld(3'b000, 32'h103, 2);                 // lb, two wait cycles
    ld(3'b100, 32'h103, 0);                 // lbu
    st(3'b001, 32'h202, 32'h0000_ABCD, 0);  // sh upper half
    ld(3'b101, 32'h202, 1);
    ld(3'b010, 32'h101, 0);                 // misaligned lw
    ld(3'b001, 32'h203, 0);                 // misaligned lh
    ld(3'b010, 32'h100, 1000);              // never ready: timeout
    ld(3'b010, 32'h104, 16);                // ready on the last allowed cycle
    ld(3'b000, 32'h102, 17);                // ready one cycle too late
    issue(1'b1, 1'b1, 1'b1, 3'b000, 32'h0000_0105, 32'h0000_0077, 0); // both set: store
    ld(3'b100, 32'h105, 0);

    // Randomized stream.
    for (int n = 0; n < 200; n++) begin
      kind = $urandom_range(0, 9);
      r = $urandom_range(0, 19);
      lat = (r < 16) ? (r % 4) : (r == 16) ? 15 : (r == 17) ? 16 : (r == 18) ? 17 : 0;
      alu = $urandom;
      if (kind <= 3) begin
        f3 = ld_f3[$urandom_range(0, 4)];
        if ($urandom_range(0, 3) != 0) alu[1:0] = 2'b00;
        issue(1'($urandom_range(0, 1)), 1'b0, 1'b1, f3, alu, $urandom, lat);
      end else if (kind <= 7) begin
        f3 = 3'($urandom_range(0, 2));
        if ($urandom_range(0, 3) != 0) alu[1:0] = 2'b00;
        issue(1'($urandom_range(0, 1)), 1'b1, (kind == 7), f3, alu, $urandom, lat);
      end else begin
        issue(1'($urandom_range(0, 1)), 1'b0, 1'b0, 3'($urandom_range(0, 7)), alu,
              $urandom, lat);
      end
    end

    // Reset while waiting on memory.
    drive_nop();
    mon_en = 1'b0;
    @(posedge clk);
    #1;
    exp_req = 1'b1; exp_we = 1'b0; exp_be = 4'b0000; exp_addr = 32'h0000_0040;
    cur_lat = 1000;
    drive(1'b1, 1'b0, 1'b1, 3'b010, 2'b01, 32'h0000_0040, 32'd0, 32'd1, 5'd9, 32'd4);
    instr_id++;
    repeat (3) @(negedge clk);
    #2;
    chk("wait_stall", {31'b0, stall_M}, 32'd1);
    chk("wait_state", {31'b0, fsm_state}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_req", {31'b0, dmem_req}, 32'd0);
    chk("arst_stall", {31'b0, stall_M}, 32'd0);
    chk("arst_state", {31'b0, fsm_state}, 32'd0);
    chk("arst_w", {write_enable_RF_W, misalign_W, bus_err_W, rd_W, write_back_W}, 32'd0);
    chk("arst_pc4", pc4_W, 32'd0);
    drive_nop();
    repeat (2) @(posedge clk);
    #1;
    chk("arst_berr", {31'b0, bus_err_W}, 32'd0);
    rst_n = 1'b1;
    mon_en = 1'b1;
    ld(3'b010, 32'h100, 1);
    st(3'b000, 32'h301, 32'h0000_00C3, 2);
    ld(3'b000, 32'h301, 0);

    drive_nop();
    mon_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("sb_leftover", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
